// File: rtl/result_capture_fifo.sv
// result_capture_fifo
// Captures result words from an upstream combinational core into a small
// first-word-fall-through FIFO, tracks a sticky overflow flag for words
// offered while full, and optionally compacts every accepted word into a
// 16-bit MISR signature.
//
// Build option: define RESULT_CAPTURE_FIFO_MISR_EN to include the MISR.
// Without it the signature port stays present and reads 16'h0000.
//
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.

module result_capture_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [15:0]            signature
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  // Handshake qualifiers. in_ready depends only on occupancy, so a word
  // offered while full is refused even if the head leaves in the same cycle.
  assign in_ready  = (count != FULL_COUNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head entry is gated by occupancy so out_data reads zero whenever the
  // FIFO is empty, including immediately on reset (storage is not reset).
  assign out_data = out_valid ? mem[rd_ptr] : '0;

  // Storage write; a flush in the same cycle discards the word.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers and occupancy; flush wins over any push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow: set when a word is offered but refused because full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (clr) begin
      overflow <= 1'b0;
    end else if (in_valid && !in_ready) begin
      overflow <= 1'b1;
    end
  end

`ifdef RESULT_CAPTURE_FIFO_MISR_EN
  logic        misr_fb;
  logic [15:0] misr_next;

  // MISR next state: shift in the feedback bit, then fold in the low byte
  // of the accepted word (zero-extended when WIDTH is narrower than 8).
  always_comb begin
    misr_fb   = signature[15] ^ signature[14] ^ signature[12] ^ signature[3];
    misr_next = {signature[14:0], misr_fb} ^ {8'h00, 8'(in_data)};
  end

  // Signature advances only on an accepted word; flush returns it to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signature <= 16'h0000;
    end else if (clr) begin
      signature <= 16'h0000;
    end else if (push) begin
      signature <= misr_next;
    end
  end
`else
  assign signature = 16'h0000;
`endif

endmodule
